draw_win_screen: RTL and testbench

End-of-game overlay stage on the vga_if pixel chain, placed directly downstream of the crown-drawing stage. After a one-cycle `win` pulse from game logic it fades the whole picture to black frame by frame, then draws a solid banner rectangle for a fixed number of frames. It then holds the dark screen and reports `done` until `restart`. When idle it is a pure 2-cycle delay of the VGA stream.

---
 rtl/draw_win_screen.sv | 258 +++++++++++++++++++++++++
 tb/tb_draw_win_screen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/draw_win_screen.sv
// draw_win_screen
//   End-of-game overlay on the VGA pixel chain. A one-cycle `win` pulse arms
//   the block. From the next frame boundary it fades the picture to black,
//   one step every FADE_FRAMES frames. It then shows a solid banner for
//   HOLD_FRAMES frames, and finally holds a dark screen with `done` high until
//   `restart`. In IDLE the stream is a plain 2-cycle delay.
//
//   Optional feature: define WIN_BANNER_BLINK_EN to blink the banner
//   (16 frames on / 16 frames off) during HOLD.
//
// Ports
//   clk, rst              pixel clock, synchronous active-high reset
//   vga_in_*              hcount/hsync/hblnk/vcount/vsync/vblnk/rgb from the crown stage
//   vga_out_*             same fields to the next stage, 2-cycle latency
//   win                   one-cycle pulse, game won (only honoured in IDLE)
//   restart               one-cycle pulse, back to IDLE (beats win and tick)
//   active                high in every state except IDLE (registered)
//   done                  high in DONE (registered)
module draw_win_screen #(
  parameter int unsigned FADE_FRAMES = 4,
  parameter int unsigned HOLD_FRAMES = 180,
  parameter int unsigned BANNER_X    = 256,
  parameter int unsigned BANNER_Y    = 272,
  parameter int unsigned BANNER_W    = 512,
  parameter int unsigned BANNER_H    = 64,
  parameter logic [11:0] BANNER_RGB  = 12'hFD0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] vga_in_hcount,
  input  logic        vga_in_hsync,
  input  logic        vga_in_hblnk,
  input  logic [10:0] vga_in_vcount,
  input  logic        vga_in_vsync,
  input  logic        vga_in_vblnk,
  input  logic [11:0] vga_in_rgb,
  output logic [10:0] vga_out_hcount,
  output logic        vga_out_hsync,
  output logic        vga_out_hblnk,
  output logic [10:0] vga_out_vcount,
  output logic        vga_out_vsync,
  output logic        vga_out_vblnk,
  output logic [11:0] vga_out_rgb,
  input  logic        win,
  input  logic        restart,
  output logic        active,
  output logic        done
);

  // state  | meaning
  // IDLE   | pass-through, waiting for win
  // ARMED  | win seen, waiting for the next frame boundary
  // FADE   | one fade step every FADE_FRAMES ticks, up to 15
  // HOLD   | picture black, banner drawn for HOLD_FRAMES ticks
  // DONE   | picture black, done high until restart
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_FADE, S_HOLD, S_DONE} state_t;

  localparam logic [9:0]  FADE_LAST = 10'(FADE_FRAMES - 1);
  localparam logic [9:0]  HOLD_LAST = 10'(HOLD_FRAMES - 1);
  // One extra bit so the right/bottom edge sum cannot wrap.
  localparam logic [11:0] X_LO = 12'(BANNER_X);
  localparam logic [11:0] X_HI = 12'(BANNER_X + BANNER_W);
  localparam logic [11:0] Y_LO = 12'(BANNER_Y);
  localparam logic [11:0] Y_HI = 12'(BANNER_Y + BANNER_H);

  state_t      state_q, state_d;
  logic [3:0]  fade_q, fade_d;
  logic [9:0]  frame_cnt_q, frame_cnt_d;
  logic        vsync_prev_q, vsync_prev_d;
  logic        active_q, active_d;
  logic        done_q, done_d;

  // Stage 1: registered copy of the input stream
  logic [10:0] s1_hcount_q, s1_hcount_d;
  logic [10:0] s1_vcount_q, s1_vcount_d;
  logic        s1_hsync_q, s1_hsync_d;
  logic        s1_hblnk_q, s1_hblnk_d;
  logic        s1_vsync_q, s1_vsync_d;
  logic        s1_vblnk_q, s1_vblnk_d;
  logic [11:0] s1_rgb_q, s1_rgb_d;

  // Stage 2: output register
  logic [10:0] s2_hcount_q, s2_hcount_d;
  logic [10:0] s2_vcount_q, s2_vcount_d;
  logic        s2_hsync_q, s2_hsync_d;
  logic        s2_hblnk_q, s2_hblnk_d;
  logic        s2_vsync_q, s2_vsync_d;
  logic        s2_vblnk_q, s2_vblnk_d;
  logic [11:0] s2_rgb_q, s2_rgb_d;

  logic        tick;
  logic        banner_hit;
  logic        banner_on;
  logic [11:0] faded_rgb;

  function automatic logic [3:0] sub_sat(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? (a - b) : 4'd0;
  endfunction

  assign tick = vga_in_vsync & ~vsync_prev_q;

  // State register (also holds the fade level, frame counter and pipeline)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fade_q       <= 4'd0;
      frame_cnt_q  <= 10'd0;
      vsync_prev_q <= 1'b0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
      s1_hcount_q  <= 11'd0;
      s1_vcount_q  <= 11'd0;
      s1_hsync_q   <= 1'b0;
      s1_hblnk_q   <= 1'b0;
      s1_vsync_q   <= 1'b0;
      s1_vblnk_q   <= 1'b0;
      s1_rgb_q     <= 12'd0;
      s2_hcount_q  <= 11'd0;
      s2_vcount_q  <= 11'd0;
      s2_hsync_q   <= 1'b0;
      s2_hblnk_q   <= 1'b0;
      s2_vsync_q   <= 1'b0;
      s2_vblnk_q   <= 1'b0;
      s2_rgb_q     <= 12'd0;
    end else begin
      state_q      <= state_d;
      fade_q       <= fade_d;
      frame_cnt_q  <= frame_cnt_d;
      vsync_prev_q <= vsync_prev_d;
      active_q     <= active_d;
      done_q       <= done_d;
      s1_hcount_q  <= s1_hcount_d;
      s1_vcount_q  <= s1_vcount_d;
      s1_hsync_q   <= s1_hsync_d;
      s1_hblnk_q   <= s1_hblnk_d;
      s1_vsync_q   <= s1_vsync_d;
      s1_vblnk_q   <= s1_vblnk_d;
      s1_rgb_q     <= s1_rgb_d;
      s2_hcount_q  <= s2_hcount_d;
      s2_vcount_q  <= s2_vcount_d;
      s2_hsync_q   <= s2_hsync_d;
      s2_hblnk_q   <= s2_hblnk_d;
      s2_vsync_q   <= s2_vsync_d;
      s2_vblnk_q   <= s2_vblnk_d;
      s2_rgb_q     <= s2_rgb_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    fade_d       = fade_q;
    frame_cnt_d  = frame_cnt_q;
    vsync_prev_d = vga_in_vsync;

    if (restart) begin
      state_d     = S_IDLE;
      fade_d      = 4'd0;
      frame_cnt_d = 10'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          fade_d      = 4'd0;
          frame_cnt_d = 10'd0;
          if (win) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (tick) begin
            state_d     = S_FADE;
            fade_d      = 4'd0;
            frame_cnt_d = 10'd0;
          end
        end
        S_FADE: begin
          if (tick) begin
            if (frame_cnt_q == FADE_LAST) begin
              frame_cnt_d = 10'd0;
              // The last step is held for a full FADE_FRAMES before HOLD.
              if (fade_q == 4'd15) state_d = S_HOLD;
              else                 fade_d  = fade_q + 4'd1;
            end else begin
              frame_cnt_d = frame_cnt_q + 10'd1;
            end
          end
        end
        S_HOLD: begin
          fade_d = 4'd15;
          if (tick) begin
            if (frame_cnt_q == HOLD_LAST) begin
              state_d     = S_DONE;
              frame_cnt_d = 10'd0;
            end else begin
              frame_cnt_d = frame_cnt_q + 10'd1;
            end
          end
        end
        S_DONE: begin
          fade_d = 4'd15;
        end
        default: begin
          state_d     = S_IDLE;
          fade_d      = 4'd0;
          frame_cnt_d = 10'd0;
        end
      endcase
    end
  end

  // Output logic: status flags and the pixel path
  always_comb begin
    active_d = (state_q != S_IDLE);
    done_d   = (state_q == S_DONE);

    s1_hcount_d = vga_in_hcount;
    s1_vcount_d = vga_in_vcount;
    s1_hsync_d  = vga_in_hsync;
    s1_hblnk_d  = vga_in_hblnk;
    s1_vsync_d  = vga_in_vsync;
    s1_vblnk_d  = vga_in_vblnk;
    s1_rgb_d    = vga_in_rgb;

    banner_hit = ({1'b0, s1_hcount_q} >= X_LO) && ({1'b0, s1_hcount_q} < X_HI) &&
                 ({1'b0, s1_vcount_q} >= Y_LO) && ({1'b0, s1_vcount_q} < Y_HI);
`ifdef WIN_BANNER_BLINK_EN
    banner_on = (state_q == S_HOLD) && banner_hit && !frame_cnt_q[4];
`else
    banner_on = (state_q == S_HOLD) && banner_hit;
`endif

    faded_rgb = {sub_sat(s1_rgb_q[11:8], fade_q),
                 sub_sat(s1_rgb_q[7:4],  fade_q),
                 sub_sat(s1_rgb_q[3:0],  fade_q)};

    s2_hcount_d = s1_hcount_q;
    s2_vcount_d = s1_vcount_q;
    s2_hsync_d  = s1_hsync_q;
    s2_hblnk_d  = s1_hblnk_q;
    s2_vsync_d  = s1_vsync_q;
    s2_vblnk_d  = s1_vblnk_q;

    // Blank forcing applies only while the overlay is engaged, so IDLE stays
    // a bit-exact delay of whatever the upstream stage produces.
    if ((state_q != S_IDLE) && (s1_hblnk_q || s1_vblnk_q)) s2_rgb_d = 12'd0;
    else if (banner_on)                                     s2_rgb_d = BANNER_RGB;
    else                                                    s2_rgb_d = faded_rgb;
  end

  assign vga_out_hcount = s2_hcount_q;
  assign vga_out_vcount = s2_vcount_q;
  assign vga_out_hsync  = s2_hsync_q;
  assign vga_out_hblnk  = s2_hblnk_q;
  assign vga_out_vsync  = s2_vsync_q;
  assign vga_out_vblnk  = s2_vblnk_q;
  assign vga_out_rgb    = s2_rgb_q;
  assign active         = active_q;
  assign done           = done_q;

endmodule

// File: tb/tb_draw_win_screen.sv
module tb_draw_win_screen;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] in_hcount, in_vcount;
  logic        in_hsync, in_hblnk, in_vsync, in_vblnk;
  logic [11:0] in_rgb;
  logic [10:0] out_hcount, out_vcount;
  logic        out_hsync, out_hblnk, out_vsync, out_vblnk;
  logic [11:0] out_rgb;
  logic        win, restart, active, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  draw_win_screen #(.FADE_FRAMES(2), .HOLD_FRAMES(3)) dut (
    .clk(clk), .rst(rst),
    .vga_in_hcount(in_hcount), .vga_in_hsync(in_hsync), .vga_in_hblnk(in_hblnk),
    .vga_in_vcount(in_vcount), .vga_in_vsync(in_vsync), .vga_in_vblnk(in_vblnk),
    .vga_in_rgb(in_rgb),
    .vga_out_hcount(out_hcount), .vga_out_hsync(out_hsync), .vga_out_hblnk(out_hblnk),
    .vga_out_vcount(out_vcount), .vga_out_vsync(out_vsync), .vga_out_vblnk(out_vblnk),
    .vga_out_rgb(out_rgb),
    .win(win), .restart(restart), .active(active), .done(done)
  );

  function automatic logic [37:0] out_vec();
    return {out_hsync, out_hblnk, out_vsync, out_vblnk, out_hcount, out_vcount, out_rgb};
  endfunction

  task automatic chk(input string tag, input logic [37:0] got, input logic [37:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [10:0] hc, input logic [10:0] vc, input logic hs,
                       input logic hb, input logic vs, input logic vb, input logic [11:0] rgb);
    in_hcount = hc; in_vcount = vc; in_hsync = hs;
    in_hblnk = hb;  in_vsync = vs;  in_vblnk = vb; in_rgb = rgb;
  endtask

  task automatic chk_px(input string tag, input logic [10:0] hc, input logic [10:0] vc,
                        input logic hb, input logic vb, input logic [11:0] rgb,
                        input logic [11:0] exp);
    drive(hc, vc, 1'b0, hb, 1'b0, vb, rgb);
    cyc();
    cyc();
    chk(tag, {26'd0, out_rgb}, {26'd0, exp});
  endtask

  task automatic frame_tick();
    in_vsync = 1'b1; in_vblnk = 1'b1;
    cyc();
    in_vsync = 1'b0; in_vblnk = 1'b0;
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) frame_tick();
  endtask

  task automatic pulse_win();
    win = 1'b1;
    cyc();
    win = 1'b0;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [37:0] prev_v, cur_v;
    logic [31:0] r;

    rst = 1'b1; win = 1'b0; restart = 1'b0;
    drive(11'd77, 11'd33, 1'b1, 1'b1, 1'b1, 1'b1, 12'hABC);
    cyc(); cyc(); cyc();
    chk("reset_out", out_vec(), 38'd0);
    chk("reset_active", {37'd0, active}, 38'd0);
    chk("reset_done", {37'd0, done}, 38'd0);

    // Idle pass-through of a random stream
    rst = 1'b0;
    prev_v = '0;
    for (int i = 0; i < 20; i++) begin
      r = $urandom;
      cur_v[37:34] = r[3:0];
      cur_v[33:23] = 11'($urandom_range(0, 2047));
      cur_v[22:12] = 11'($urandom_range(0, 2047));
      cur_v[11:0]  = (r[6] | r[4]) ? 12'h000 : r[27:16];
      drive(cur_v[33:23], cur_v[22:12], cur_v[37], cur_v[36], cur_v[35], cur_v[34], cur_v[11:0]);
      cyc();
      if (i >= 1) chk("idle_passthru", out_vec(), prev_v);
      prev_v = cur_v;
    end
    chk("idle_active", {37'd0, active}, 38'd0);
    chk_px("idle_settle", 11'd100, 11'd100, 1'b0, 1'b0, 12'hA5F, 12'hA5F);

    // Win mid-frame; the fade waits for the next vsync rise
    pulse_win();
    chk("armed_active", {37'd0, active}, 38'd1);
    chk_px("armed_px", 11'd100, 11'd100, 1'b0, 1'b0, 12'hA5F, 12'hA5F);
    frame_tick();                                                     // k=0
    chk_px("fade_k0", 11'd100, 11'd100, 1'b0, 1'b0, 12'hA5F, 12'hA5F);
    ticks(1);                                                         // k=1
    chk_px("fade_k1", 11'd100, 11'd100, 1'b0, 1'b0, 12'hA5F, 12'hA5F);
    ticks(1);                                                         // k=2, fade 1
    chk_px("fade_1", 11'd100, 11'd100, 1'b0, 1'b0, 12'hA5F, 12'h94E);
    ticks(2);                                                         // fade 2
    chk_px("fade_2", 11'd100, 11'd100, 1'b0, 1'b0, 12'hA5F, 12'h83D);
    ticks(6);                                                         // fade 5
    chk_px("fade_5", 11'd100, 11'd100, 1'b0, 1'b0, 12'hA5F, 12'h50A);
    ticks(2);                                                         // fade 6
    chk_px("fade_6", 11'd100, 11'd100, 1'b0, 1'b0, 12'hA5F, 12'h409);
    chk_px("saturate_6", 11'd100, 11'd100, 1'b0, 1'b0, 12'h3C2, 12'h060);
    ticks(8);                                                         // fade 10
    chk_px("fade_10", 11'd100, 11'd100, 1'b0, 1'b0, 12'hA5F, 12'h005);
    ticks(8);                                                         // fade 14
    chk_px("fade_14", 11'd100, 11'd100, 1'b0, 1'b0, 12'hA5F, 12'h001);
    ticks(2);                                                         // fade 15
    chk_px("fade_15", 11'd100, 11'd100, 1'b0, 1'b0, 12'hFFF, 12'h000);
    ticks(1);                                                         // k=31, still FADE
    chk_px("no_banner_in_fade", 11'd256, 11'd272, 1'b0, 1'b0, 12'hA5F, 12'h000);
    ticks(1);                                                         // k=32, HOLD

    chk_px("banner_tl", 11'd256, 11'd272, 1'b0, 1'b0, 12'hA5F, 12'hFD0);
    chk_px("banner_left_out", 11'd255, 11'd272, 1'b0, 1'b0, 12'hA5F, 12'h000);
    chk_px("banner_right_out", 11'd768, 11'd272, 1'b0, 1'b0, 12'hA5F, 12'h000);
    chk_px("banner_br", 11'd767, 11'd335, 1'b0, 1'b0, 12'hA5F, 12'hFD0);
    chk_px("banner_below_out", 11'd256, 11'd336, 1'b0, 1'b0, 12'hA5F, 12'h000);
    chk_px("banner_above_out", 11'd300, 11'd271, 1'b0, 1'b0, 12'hA5F, 12'h000);
    chk_px("banner_hblnk", 11'd300, 11'd300, 1'b1, 1'b0, 12'hA5F, 12'h000);
    chk_px("banner_vblnk", 11'd300, 11'd300, 1'b0, 1'b1, 12'hA5F, 12'h000);
    chk("hold_done", {37'd0, done}, 38'd0);
    ticks(2);                                                         // 2 ticks in HOLD
    chk_px("banner_late", 11'd400, 11'd300, 1'b0, 1'b0, 12'hA5F, 12'hFD0);
    chk("hold_done2", {37'd0, done}, 38'd0);

    // Third tick in HOLD: DONE, done rises one cycle later
    in_vsync = 1'b1; in_vblnk = 1'b1;
    cyc();
    chk("done_lag", {37'd0, done}, 38'd0);
    in_vsync = 1'b0; in_vblnk = 1'b0;
    cyc();
    chk("done_rise", {37'd0, done}, 38'd1);
    chk_px("done_no_banner", 11'd256, 11'd272, 1'b0, 1'b0, 12'hA5F, 12'h000);
    chk("done_active", {37'd0, active}, 38'd1);

    restart = 1'b1;
    cyc();
    restart = 1'b0;
    cyc();
    chk("restart_active", {37'd0, active}, 38'd0);
    chk("restart_done", {37'd0, done}, 38'd0);
    chk_px("restart_passthru", 11'd256, 11'd272, 1'b0, 1'b0, 12'hA5F, 12'hA5F);

    // restart and win together in HOLD
    pulse_win();
    ticks(33);
    chk_px("hold2_banner", 11'd256, 11'd272, 1'b0, 1'b0, 12'hA5F, 12'hFD0);
    restart = 1'b1; win = 1'b1;
    cyc();
    restart = 1'b0; win = 1'b0;
    cyc();
    chk("prio_active", {37'd0, active}, 38'd0);
    ticks(3);
    chk("prio_active_later", {37'd0, active}, 38'd0);
    chk_px("prio_passthru", 11'd256, 11'd272, 1'b0, 1'b0, 12'hA5F, 12'hA5F);

    // Reset pulse during FADE
    pulse_win();
    ticks(5);
    chk_px("rst_pre_fade2", 11'd100, 11'd100, 1'b0, 1'b0, 12'hA5F, 12'h83D);
    drive(11'd10, 11'd10, 1'b1, 1'b0, 1'b0, 1'b0, 12'hA5F);
    rst = 1'b1;
    cyc();
    chk("rst_mid_out", out_vec(), 38'd0);
    chk("rst_mid_active", {37'd0, active}, 38'd0);
    rst = 1'b0;
    cyc();
    cyc();
    chk("rst_first_px", out_vec(), {1'b1, 1'b0, 1'b0, 1'b0, 11'd10, 11'd10, 12'hA5F});
    chk("rst_after_active", {37'd0, active}, 38'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
